// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, default
// geometry and the supported input-count limit.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int N_IN_DEFAULT   = 2;
  localparam int SETTLE_DEFAULT = 2;
  localparam int N_IN_MAX       = 4;

  // Bits needed to count 0..settle-1, never less than one.
  function automatic int settle_cnt_width(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status bundle of the sweeper: the sweep request plus the
// completion flags and captured truth table.
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  logic                 start;
  logic [2**N_IN-1:0]   expected;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN-1:0]      fail_idx;
  logic [2**N_IN-1:0]   result_table;

  modport master (
    output start, expected,
    input  busy, done, pass, fail_idx, result_table
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, fail_idx, result_table
  );
endinterface

// File: rtl/truth_table_sweeper_settle_cnt.sv
// Clearable settle-time up-counter; tc flags the last settle cycle of a
// vector so the FSM can move to its sample cycle.
module sweep_settle_cnt
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = settle_cnt_width(SETTLE);

  logic [CW-1:0] cnt;

  // Overflow past SETTLE-1 is harmless: the FSM clears before reuse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a small gate network through every input vector in ascending
// order, samples its output after a settle time and grades the truth table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave ctl,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in
);

  localparam int NV = 2**N_IN;

  sweep_state_t    state;
  logic [NV-1:0]   exp_q;
  logic [N_IN-1:0] idx;
  logic            fail_q;
  logic            accept;
  logic            miss;
  logic            last;
  logic            cnt_clr;
  logic            cnt_en;
  logic            tc;

  assign accept  = ((state == ST_IDLE) || (state == ST_DONE)) && ctl.start;
  assign miss    = (dut_out != exp_q[idx]);
  assign last    = &idx;
  assign cnt_clr = accept || ((state == ST_SAMPLE) && !last);
  assign cnt_en  = (state == ST_SETTLE);

  sweep_settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      exp_q            <= '0;
      idx              <= '0;
      fail_q           <= 1'b0;
      dut_in           <= '0;
      ctl.busy         <= 1'b0;
      ctl.done         <= 1'b0;
      ctl.pass         <= 1'b0;
      ctl.fail_idx     <= '0;
      ctl.result_table <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            exp_q            <= ctl.expected;
            ctl.result_table <= '0;
            fail_q           <= 1'b0;
            ctl.fail_idx     <= '0;
            idx              <= '0;
            dut_in           <= '0;
            ctl.busy         <= 1'b1;
            ctl.done         <= 1'b0;
            ctl.pass         <= 1'b0;
            state            <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tc) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          ctl.result_table[idx] <= dut_out;
          // Only the first mismatch is reported; later ones are absorbed.
          if (miss && !fail_q) begin
            fail_q       <= 1'b1;
            ctl.fail_idx <= idx;
          end
          if (last) begin
            ctl.busy <= 1'b0;
            ctl.done <= 1'b1;
            ctl.pass <= !(fail_q || miss);
            state    <= ST_DONE;
          end else begin
            idx    <= idx + 1'b1;
            dut_in <= idx + 1'b1;
            state  <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synchronous stimulus-and-capture stage that sits directly upstream of a small combinational gate network. It drives the network inputs through every input combination in ascending binary order and waits a programmable settle time per vector. It samples the single network output and assembles the observed truth table, comparing it against an expected table and reporting pass/fail plus the first failing vector. It replaces hand-written delay-based stimulus with a clocked, self-checking sweep.

## Interface
Parameters:
- N_IN, 2, number of network inputs; legal range 1..4.
- SETTLE, 2, clock cycles each vector is held before sampling; minimum 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; accepted only in IDLE or DONE.
- expected  in  2**N_IN  expected output per vector; bit i is the expected output for input value i; latched when start is accepted.
- dut_out  in  1  network output under test.
- dut_in  out  N_IN  network input vector; MSB drives the first network input (a), LSB the second (b).
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  high in DONE; held until the next accepted start or reset.
- pass  out  1  done & no mismatch.
- fail_idx  out  N_IN  first mismatching vector index; valid when done & ~pass.
- result_table  out  2**N_IN  captured outputs; bit i is the value sampled for vector i.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Async reset: IDLE; dut_in, busy, done, pass, fail_idx, result_table, internal index, settle count, fail flag and latched expected all 0.
- IDLE or DONE with start=1: latch expected, clear result_table, fail flag and fail_idx; set idx=0, dut_in=0, cnt=0; go to SETTLE.
- SETTLE: cnt increments each cycle; at cnt==SETTLE-1 go to SAMPLE. dut_in is stable.
- SAMPLE (one cycle): result_table[idx]<=dut_out. If dut_out != exp_q[idx] and the fail flag is clear, set the fail flag and fail_idx<=idx. If idx==2**N_IN-1, go to DONE. Otherwise idx<=idx+1, dut_in<=idx+1, cnt<=0, go to SETTLE.
- DONE: dut_in holds the last vector (all ones). pass = ~fail flag, registered.
- start while busy: ignored, with no effect on state, latched expected or outputs.
- Later mismatches: do not change fail_idx; the first failure is retained.
- Index and dut_in are N_IN bits wide. The end-of-sweep test is done on idx before increment, so no wrap-around occurs.

## Timing
- Each vector occupies SETTLE+1 cycles. dut_in is stable for SETTLE+1 rising edges before the capture edge.
- done rises on the edge 2**N_IN*(SETTLE+1) edges after the start-accepting edge. With defaults, done rises 12 edges after acceptance, and vector k is captured on edge 3k+3.
- All outputs are registered; there is no combinational path from dut_out to any output.
- busy falls on the same edge done rises.
- Reset mid-sweep: immediate return to the reset state. The partial result_table is discarded.
- start on the same cycle as reset deassertion: ignored, because rst_n must be high at the sampling edge.

## Structure
- Shared header (included) holds: state encodings (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), the default N_IN and SETTLE, and the N_IN legality limit.
- One natural sub-module is sweep_settle_cnt: a clearable up-counter with a terminal-count output at SETTLE-1, instantiated once.
- The FSM, index register, capture/compare logic and output registers stay in truth_table_sweeper.

## Test plan
- Reset with rst_n=0, then release -> all outputs 0 and state IDLE. Pulse start with expected=4'b0000 on the network Y=(~a&b)&(a&b) -> dut_in steps 00,01,10,11; done at edge 12; pass=1; result_table=4'b0000.
- Same network with expected=4'b1000 (a plain AND) -> done at edge 12; pass=0; fail_idx=2'd3; result_table=4'b0000.
- Single AND network with expected=4'b0100 -> first mismatch at vector 2 -> fail_idx=2; a later mismatch at vector 3 does not change fail_idx.
- Pulse start again during the SETTLE of vector 1 -> ignored; done still at edge 12 counted from the original start.
- Assert rst_n=0 during SAMPLE of vector 2 -> outputs clear immediately. A new start then completes a full 12-cycle sweep with fresh results.
- SETTLE=4 with N_IN=3 -> done 40 edges after start; every dut_in value is held for exactly 5 edges.
